// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: one Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Define MC_MULTU_EN to include the MULTU state, latency counter and HI/LO writeback controls.
module mc_ctrl_fsm #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       branch,
  output logic       ir_we,
  output logic       iord,
  output logic       we_dm,
  output logic       dm2reg,
  output logic       we_reg,
  output logic [1:0] reg_dst,
  output logic       link_en,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       shift_en,
  output logic       shift_dir,
  output logic [1:0] pc_src,
  output logic       hilo_we,
  output logic       mf_en,
  output logic       hilo_sel,
  output logic       busy,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_JR    = 6'b001000;
`ifdef MC_MULTU_EN
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXE, S_RTWB, S_ADDIEXE, S_ADDIWB, S_BEQ, S_JUMP, S_JAL, S_JR,
    S_ILLEGAL
`ifdef MC_MULTU_EN
    , S_MULT
`endif
  } state_t;

  state_t state, next_state;

  logic       rt_legal, rt_shift, rt_dir, rt_mf, rt_mfhi;
  logic [2:0] rt_alu;

  always_comb begin
    rt_legal = 1'b1;
    rt_alu   = ALU_AND;
    rt_shift = 1'b0;
    rt_dir   = 1'b0;
    rt_mf    = 1'b0;
    rt_mfhi  = 1'b0;
    case (funct)
      F_ADD: rt_alu = ALU_ADD;
      F_SUB: rt_alu = ALU_SUB;
      F_AND: rt_alu = ALU_AND;
      F_OR:  rt_alu = ALU_OR;
      F_SLT: rt_alu = ALU_SLT;
      F_SLL: begin rt_shift = 1'b1; rt_dir = 1'b1; end
      F_SRL: rt_shift = 1'b1;
`ifdef MC_MULTU_EN
      F_MFHI: begin rt_mf = 1'b1; rt_mfhi = 1'b1; end
      F_MFLO: rt_mf = 1'b1;
`endif
      default: rt_legal = 1'b0;
    endcase
  end

`ifdef MC_MULTU_EN
  logic [3:0] mult_cnt;

  // Counter is loaded on the DECODE->MULT transition so the first MULT cycle sees MULT_CYCLES-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mult_cnt <= 4'd0;
    else if (state == S_DECODE && next_state == S_MULT)
      mult_cnt <= 4'(MULT_CYCLES - 1);
    else if (state == S_MULT && mult_cnt != 4'd0)
      mult_cnt <= mult_cnt - 4'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Outputs stay at their zero defaults while rst is high, whatever the state or mem_ready
  always_comb begin
    next_state = state;
    pc_we = 1'b0; branch = 1'b0; ir_we = 1'b0; iord = 1'b0;
    we_dm = 1'b0; dm2reg = 1'b0; we_reg = 1'b0; reg_dst = 2'b00;
    link_en = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; alu_ctrl = 3'b000;
    shift_en = 1'b0; shift_dir = 1'b0; pc_src = 2'b00; hilo_we = 1'b0;
    mf_en = 1'b0; hilo_sel = 1'b0; busy = 1'b0; illegal = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          alu_src_b = 2'b01; alu_ctrl = ALU_ADD;
          ir_we = mem_ready; pc_we = mem_ready;
          if (mem_ready) next_state = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11; alu_ctrl = ALU_ADD;
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_RTYPE: begin
              if (funct == F_JR) next_state = S_JR;
`ifdef MC_MULTU_EN
              else if (funct == F_MULTU) next_state = S_MULT;
`endif
              else next_state = S_RTEXE;
            end
            OP_ADDI: next_state = S_ADDIEXE;
            OP_BEQ:  next_state = S_BEQ;
            OP_J:    next_state = S_JUMP;
            OP_JAL:  next_state = S_JAL;
            default: next_state = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1; alu_src_b = 2'b10; alu_ctrl = ALU_ADD;
          next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iord = 1'b1;
          if (mem_ready) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          dm2reg = 1'b1; we_reg = 1'b1; next_state = S_FETCH;
        end
        S_MEMWR: begin
          iord = 1'b1; we_dm = 1'b1;
          if (mem_ready) next_state = S_FETCH;
        end
        S_RTEXE: begin
          alu_src_a = 1'b1; alu_ctrl = rt_alu;
          shift_en = rt_shift; shift_dir = rt_dir;
          next_state = rt_legal ? S_RTWB : S_ILLEGAL;
        end
        S_RTWB: begin
          reg_dst = 2'b01; we_reg = 1'b1;
          mf_en = rt_mf; hilo_sel = rt_mfhi;
          next_state = S_FETCH;
        end
        S_ADDIEXE: begin
          alu_src_a = 1'b1; alu_src_b = 2'b10; alu_ctrl = ALU_ADD;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          we_reg = 1'b1; next_state = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a = 1'b1; alu_ctrl = ALU_SUB; branch = 1'b1; pc_src = 2'b01;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pc_src = 2'b10; pc_we = 1'b1; next_state = S_FETCH;
        end
        S_JAL: begin
          pc_src = 2'b10; pc_we = 1'b1; we_reg = 1'b1; reg_dst = 2'b10; link_en = 1'b1;
          next_state = S_FETCH;
        end
        S_JR: begin
          pc_src = 2'b11; pc_we = 1'b1; next_state = S_FETCH;
        end
`ifdef MC_MULTU_EN
        S_MULT: begin
          busy = 1'b1;
          if (mult_cnt == 4'd0) begin
            hilo_we = 1'b1; next_state = S_FETCH;
          end
        end
`endif
        S_ILLEGAL: illegal = 1'b1;
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: a per-cycle reference of the control outputs is
// queued as stimulus is driven, and a negedge monitor pops and compares it against the DUT.
module tb_mc_ctrl_fsm;

  localparam int MC = 4;
  localparam int ILL_HOLD = 10;
`ifdef MC_MULTU_EN
  localparam bit MULTU_ON = 1'b1;
`else
  localparam bit MULTU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic mem_ready;
  logic pc_we, branch, ir_we, iord, we_dm, dm2reg, we_reg, link_en, alu_src_a;
  logic shift_en, shift_dir, hilo_we, mf_en, hilo_sel, busy, illegal;
  logic [1:0] reg_dst, alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_we(pc_we), .branch(branch), .ir_we(ir_we), .iord(iord), .we_dm(we_dm),
    .dm2reg(dm2reg), .we_reg(we_reg), .reg_dst(reg_dst), .link_en(link_en),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .shift_en(shift_en), .shift_dir(shift_dir), .pc_src(pc_src), .hilo_we(hilo_we),
    .mf_en(mf_en), .hilo_sel(hilo_sel), .busy(busy), .illegal(illegal)
  );

  typedef struct packed {
    logic pc_we, branch, ir_we, iord, we_dm, dm2reg, we_reg;
    logic [1:0] reg_dst;
    logic link_en, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic shift_en, shift_dir;
    logic [1:0] pc_src;
    logic hilo_we, mf_en, hilo_sel, busy, illegal;
  } outs_t;

  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  exp_t  sb[$];
  outs_t plan_v[$];
  bit    plan_mr[$];
  bit    plan_ill;
  int    n_cmp = 0;
  int    n_bad = 0;

  // R-type table keyed by funct: {mf_en, hilo_sel, shift_en, shift_dir, alu_ctrl}
  logic [6:0] rt_tab [logic [5:0]];

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(outs_t o, bit m);
    plan_v.push_back(o);
    plan_mr.push_back(m);
  endfunction

  function automatic void illegal_tail();
    outs_t o = '0;
    o.illegal = 1'b1;
    repeat (ILL_HOLD) add(o, rnd());
    plan_ill = 1'b1;
  endfunction

  // Expected per-cycle outputs and mem_ready schedule for one instruction, from the state action list
  function automatic void build(logic [5:0] op, logic [5:0] fn, int wf, int wm);
    outs_t o;
    logic [6:0] t;
    plan_v.delete(); plan_mr.delete(); plan_ill = 1'b0;
    o = '0; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
    repeat (wf) add(o, 1'b0);
    o.ir_we = 1'b1; o.pc_we = 1'b1; add(o, 1'b1);
    o = '0; o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; add(o, rnd());
    case (op)
      6'b100011, 6'b101011: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; add(o, rnd());
        o = '0; o.iord = 1'b1; o.we_dm = (op == 6'b101011);
        repeat (wm) add(o, 1'b0);
        add(o, 1'b1);
        if (op == 6'b100011) begin
          o = '0; o.dm2reg = 1'b1; o.we_reg = 1'b1; add(o, rnd());
        end
      end
      6'b000000: begin
        if (fn == 6'b001000) begin
          o = '0; o.pc_src = 2'b11; o.pc_we = 1'b1; add(o, rnd());
        end else if (fn == 6'b011001 && MULTU_ON) begin
          for (int i = 1; i <= MC; i++) begin
            o = '0; o.busy = 1'b1; o.hilo_we = (i == MC); add(o, rnd());
          end
        end else if (rt_tab.exists(fn)) begin
          t = rt_tab[fn];
          o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = t[2:0]; o.shift_en = t[4]; o.shift_dir = t[3];
          add(o, rnd());
          o = '0; o.reg_dst = 2'b01; o.we_reg = 1'b1; o.mf_en = t[6]; o.hilo_sel = t[5];
          add(o, rnd());
        end else begin
          o = '0; o.alu_src_a = 1'b1; add(o, rnd());
          illegal_tail();
        end
      end
      6'b001000: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; add(o, rnd());
        o = '0; o.we_reg = 1'b1; add(o, rnd());
      end
      6'b000100: begin
        o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.branch = 1'b1; o.pc_src = 2'b01;
        add(o, rnd());
      end
      6'b000010: begin
        o = '0; o.pc_src = 2'b10; o.pc_we = 1'b1; add(o, rnd());
      end
      6'b000011: begin
        o = '0; o.pc_src = 2'b10; o.pc_we = 1'b1; o.we_reg = 1'b1; o.reg_dst = 2'b10;
        o.link_en = 1'b1; add(o, rnd());
      end
      default: illegal_tail();
    endcase
  endfunction

  task automatic applyStimulus(outs_t e, bit m, string tag, logic [5:0] op, logic [5:0] fn);
    exp_t x;
    mem_ready = m; opcode = op; funct = fn;
    x.v = e; x.tag = tag;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic applyReset(int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++)
      applyStimulus('0, 1'b1, $sformatf("reset[%0d]", i), 6'($urandom), 6'($urandom));
    rst = 1'b0;
  endtask

  // Plays one instruction; opcode/funct are junk during FETCH since IR is not yet loaded
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, int wf, int wm, int abort_at);
    build(op, fn, wf, wm);
    for (int i = 0; i < plan_v.size(); i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      if (i <= wf)
        applyStimulus(plan_v[i], plan_mr[i], $sformatf("%s[%0d]", name, i), 6'($urandom), 6'($urandom));
      else
        applyStimulus(plan_v[i], plan_mr[i], $sformatf("%s[%0d]", name, i), op, fn);
    end
    if (abort_at >= 0 || plan_ill) applyReset(2);
  endtask

  task automatic checkOutput();
    exp_t  e;
    outs_t act;
    e = sb.pop_front();
    act = {pc_we, branch, ir_we, iord, we_dm, dm2reg, we_reg, reg_dst, link_en, alu_src_a,
           alu_src_b, alu_ctrl, shift_en, shift_dir, pc_src, hilo_we, mf_en, hilo_sel, busy, illegal};
    n_cmp++;
    if (act !== e.v) begin
      n_bad++;
      $display("[TB] FAIL %s: outputs got %b expected %b", e.tag, act, e.v);
    end
  endtask

  always @(negedge clk)
    if (sb.size() > 0) checkOutput();

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [5:0] pool_op [17] = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h04, 6'h02, 6'h03};
  logic [5:0] pool_fn [17] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02,
                               6'h10, 6'h12, 6'h08, 6'h19, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    rt_tab[6'b100000] = 7'b00_00_010;
    rt_tab[6'b100010] = 7'b00_00_110;
    rt_tab[6'b100100] = 7'b00_00_000;
    rt_tab[6'b100101] = 7'b00_00_001;
    rt_tab[6'b101010] = 7'b00_00_111;
    rt_tab[6'b000000] = 7'b00_11_000;
    rt_tab[6'b000010] = 7'b00_10_000;
    if (MULTU_ON) begin
      rt_tab[6'b010000] = 7'b11_00_000;
      rt_tab[6'b010010] = 7'b10_00_000;
    end

    rst = 1'b1; mem_ready = 1'b1; opcode = '0; funct = '0;
    @(posedge clk); #1;
    applyReset(3);

    run_instr("lw_fetchwait", 6'b100011, 6'h00, 3, 0, -1);
    run_instr("sw_memwait",   6'b101011, 6'h00, 0, 2, -1);
    run_instr("beq",          6'b000100, 6'h00, 0, 0, -1);
    run_instr("jal",          6'b000011, 6'h00, 0, 0, -1);
    run_instr("multu",        6'b000000, 6'b011001, 0, 0, -1);
    run_instr("mfhi",         6'b000000, 6'b010000, 0, 0, -1);
    run_instr("addi",         6'b001000, 6'h00, 1, 0, -1);
    run_instr("jr",           6'b000000, 6'b001000, 0, 0, -1);

    for (int k = 0; k < 150; k++) begin
      int idx;
      if ($urandom_range(0, 9) == 0)
        run_instr("rnd_any", 6'($urandom), 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
      else begin
        idx = $urandom_range(0, 16);
        run_instr($sformatf("rnd_%h_%h", pool_op[idx], pool_fn[idx]), pool_op[idx], pool_fn[idx],
                  $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end
    end

    run_instr("multu_abort", 6'b000000, 6'b011001, 0, 0, 4);
    run_instr("j_after_rst", 6'b000010, 6'h00, 0, 0, -1);
    run_instr("illegal_op",  6'b111111, 6'h00, 0, 0, -1);
    run_instr("multu_late",  6'b000000, 6'b011001, 1, 0, -1);
    run_instr("lw_final",    6'b100011, 6'h00, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

- Multicycle MIPS control unit. It replaces the single-cycle main/ALU decoder pair with one Moore-style state machine that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory ready handshake and a parametrised-latency MULTU with HI/LO writeback.
- Sits between the instruction register (opcode/funct) and the shared-memory multicycle datapath.

## Interface
Parameters:
- MULT_CYCLES, 4, multiply latency in cycles spent in MULT state; legal 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory access complete this cycle.
- pc_we  out  1  unconditional PC write.
- branch  out  1  PC write if ALU zero (gated externally).
- ir_we  out  1  instruction register write.
- iord  out  1  memory address: 0=PC, 1=ALUOut.
- we_dm  out  1  data memory write.
- dm2reg  out  1  writeback from memory data register.
- we_reg  out  1  register file write.
- reg_dst  out  2  00=rt, 01=rd, 10=$31.
- link_en  out  1  writeback PC (JAL).
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- shift_en, shift_dir  out  1,1  shifter enable; dir 1=left.
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs.
- hilo_we  out  1  load HI/LO from multiplier.
- mf_en, hilo_sel  out  1,1  writeback from HI/LO; sel 1=HI.
- busy  out  1  multiply in progress.
- illegal  out  1  sticky unrecognised-instruction flag.

## Operation
States and actions. Unlisted outputs are 0.
- **FETCH:** iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - ir_we=pc_we=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- **DECODE:** alu_src_a=0, alu_src_b=11, add. Next state by opcode:
  - 100011/101011 → MEMADR
  - 000000 → RTEXE; funct 001000 → JR; funct 011001 → MULT
  - 001000 → ADDIEXE
  - 000100 → BEQ
  - 000010 → JUMP
  - 000011 → JAL
  - anything else → ILLEGAL
- **MEMADR:** alu_src_a=1, alu_src_b=10, add. Goes to MEMRD (lw) or MEMWR (sw).
- **MEMRD:** iord=1. Stays until mem_ready=1, then MEMWB.
- **MEMWB:** reg_dst=00, dm2reg=1, we_reg=1. Returns to FETCH.
- **MEMWR:** iord=1, we_dm=1, held while waiting. Goes to FETCH on mem_ready=1.
- **RTEXE:** alu_src_a=1, alu_src_b=00. ALU control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - 000000 sll (shift_en=1, dir=1); 000010 srl (shift_en=1, dir=0).
  - 010000/010010 (mfhi/mflo) no ALU op.
  - Any other funct goes to ILLEGAL; otherwise goes to RTWB.
- **RTWB:** reg_dst=01, we_reg=1. mf_en=1 for mfhi/mflo, with hilo_sel=1 for mfhi. Returns to FETCH.
- **ADDIEXE:** alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
- **ADDIWB:** reg_dst=00, we_reg=1. Returns to FETCH.
- **BEQ:** alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01. Returns to FETCH.
- **JUMP:** pc_src=10, pc_we=1. Returns to FETCH.
- **JAL:** pc_src=10, pc_we=1, we_reg=1, reg_dst=10, link_en=1. Returns to FETCH.
- **JR:** pc_src=11, pc_we=1. Returns to FETCH.
- **MULT:** busy=1.
  - A 4-bit counter loads MULT_CYCLES-1 on entry and decrements each cycle.
  - When the count reaches 0, hilo_we=1 for that cycle only, then FETCH.
- **ILLEGAL:** illegal=1; all enables 0. No exit except rst.

Rules:
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- opcode/funct only need to be stable from DECODE to the end of the instruction (IR is written only in FETCH).

## Timing
Cycles per instruction, with zero wait states:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type, addi | 4 |
| beq, j, jal, jr | 3 |
| multu | 2+MULT_CYCLES |

- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Reset:
  - rst asserted: state=FETCH, counter=0, illegal=0.
  - While rst is high, every output is 0 (ir_we/pc_we forced low regardless of mem_ready).
- Reset mid-instruction: the operation is abandoned. No we_reg, we_dm or hilo_we is issued after rst rises. First FETCH follows the first clk edge after rst falls.
- MULT_CYCLES=1: hilo_we fires in the first MULT cycle.

## Configuration
- MC_MULTU_EN defined:
  - MULT state, counter, busy, hilo_we, mf_en and hilo_sel are present.
  - funct 011001/010000/010010 decode as above.
- MC_MULTU_EN undefined:
  - The MULT state and counter are removed; MULT_CYCLES is ignored.
  - busy, hilo_we, mf_en and hilo_sel are tied 0.
  - MULTU/MFHI/MFLO funct codes go to ILLEGAL.

## Test plan
- **Reset and fetch wait:**
  - Stimulus: rst high, mem_ready=1 → all outputs 0.
  - Release rst, hold mem_ready=0 for 3 cycles → FETCH held, ir_we=0. Then mem_ready=1 → ir_we=pc_we=1 for one cycle.
- **lw:** opcode 100011, mem_ready=1 throughout → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; we_reg=dm2reg=1 in cycle 5 only.
- **sw:** opcode 101011, mem_ready low for 2 cycles in MEMWR → we_dm=1 for 3 consecutive cycles, then FETCH.
- **beq and jal:**
  - beq: branch=1, alu_ctrl=110 in cycle 3.
  - jal: pc_we=we_reg=link_en=1, reg_dst=10 in cycle 3.
- **multu:** MULT_CYCLES=4, funct 011001 → busy=1 for 4 cycles, hilo_we=1 only in the last of them. Next instruction mfhi → RTWB has mf_en=1, hilo_sel=1.
- **Illegal and reset:**
  - opcode 111111 → illegal=1, held for 10 cycles with no enables.
  - rst asserted during MULT → no hilo_we; after release the block is in FETCH.
  - Build without MC_MULTU_EN: funct 011001 → illegal=1.
